// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and the select/op codes driven onto the datapath muxes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      JAL      = 4'd8,
      ALUWB    = 4'd9,
      BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format is a pure function of the opcode, independent of state.
   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: Moore control word per state, with
// mem_ready stretching FETCH/MEMREAD/MEMWRITE and Zero gating the branch.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal
);

   state_t state, state_nxt;
   logic   branch, pcupdate;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = EXECUTER;
               OP_IALU:      state_nxt = EXECUTEI;
               OP_JAL:       state_nxt = JAL;
               OP_BEQ:       state_nxt = BEQ;
               default:      state_nxt = FETCH;
            endcase
         end
         MEMADR:   state_nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
         EXECUTER: state_nxt = ALUWB;
         EXECUTEI: state_nxt = ALUWB;
         JAL:      state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         BEQ:      state_nxt = FETCH;
         default:  state_nxt = FETCH;
      endcase
   end

   always_comb begin
      branch     = 1'b0;
      pcupdate   = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ALUOp      = ALUOP_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = mem_ready;
            pcupdate  = mem_ready;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            // Unsupported opcodes retire here and go straight back to FETCH.
            case (opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_JAL, OP_BEQ: ;
               default: begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            ALUOp   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALUOUT;
            pcupdate  = 1'b1;
         end
         ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         BEQ: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_RD2;
            ALUOp      = ALUOP_SUB;
            ResultSrc  = RES_ALUOUT;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite = (branch & Zero) | pcupdate;
   assign ImmSrc  = imm_src(opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words
// are queued by the stimulus and compared by an independent negedge monitor.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic       instr_done, illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [16:0] exp;
   } exp_t;

   exp_t sbq[$];

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [16:0] act;
   assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal};

   // Field order: pcw adr mw irw rw | rs sa sb op imm | done ill
   function automatic logic [16:0] ctl(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb, op, imm,
                                       input logic done, ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, op, imm, done, ill};
   endfunction

   function automatic logic [16:0] w_fetch(input logic mr, input logic [1:0] imm);
      return ctl(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
   endfunction

   function automatic logic [16:0] w_decode(input logic [1:0] imm);
      return ctl(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", e.name, act, e.exp);
         end
      end
   end

   task automatic cyc(input string nm, input logic [6:0] op, input logic mr,
                      input logic z, input logic [16:0] e);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = mr;
      Zero      = z;
      sbq.push_back('{nm, e});
   endtask

   task automatic chk(input string nm, input logic [16:0] a, input logic [16:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, a, e);
      end
   endtask

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;
   localparam logic [6:0] BQ = 7'b1100011;
   localparam logic [6:0] JL = 7'b1101111;
   localparam logic [6:0] XX = 7'b0000000;

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; opcode = XX; mem_ready = 1'b0; Zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", act, ctl(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
      rst = 1'b0;

      // R-type, 4 cycles
      cyc("r_fetch",  R, 1, 0, w_fetch(1, 2'b00));
      cyc("r_decode", R, 1, 0, w_decode(2'b00));
      cyc("r_exec",   R, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0));
      cyc("r_wb",     R, 1, 0, ctl(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));

      // I-ALU, 4 cycles
      cyc("i_fetch",  I, 1, 0, w_fetch(1, 2'b00));
      cyc("i_decode", I, 1, 0, w_decode(2'b00));
      cyc("i_exec",   I, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0));
      cyc("i_wb",     I, 1, 0, ctl(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));

      // lw with two wait cycles in MEMREAD: 7 cycles
      cyc("lw_fetch",  LW, 1, 0, w_fetch(1, 2'b00));
      cyc("lw_decode", LW, 1, 0, w_decode(2'b00));
      cyc("lw_memadr", LW, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
      cyc("lw_rd_w1",  LW, 0, 0, ctl(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
      cyc("lw_rd_w2",  LW, 0, 0, ctl(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
      cyc("lw_rd",     LW, 1, 0, ctl(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
      cyc("lw_wb",     LW, 1, 0, ctl(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 1,0));

      // sw with one wait cycle in MEMWRITE
      cyc("sw_fetch",  SW, 1, 0, w_fetch(1, 2'b01));
      cyc("sw_decode", SW, 1, 0, w_decode(2'b01));
      cyc("sw_memadr", SW, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
      cyc("sw_wr_w1",  SW, 0, 0, ctl(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
      cyc("sw_wr",     SW, 1, 0, ctl(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 1,0));

      // beq taken, then not taken
      cyc("beq1_fetch",  BQ, 1, 1, w_fetch(1, 2'b10));
      cyc("beq1_decode", BQ, 1, 1, w_decode(2'b10));
      cyc("beq1_taken",  BQ, 1, 1, ctl(1,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 1,0));
      cyc("beq0_fetch",  BQ, 1, 0, w_fetch(1, 2'b10));
      cyc("beq0_decode", BQ, 1, 0, w_decode(2'b10));
      cyc("beq0_nottkn", BQ, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 1,0));

      // jal
      cyc("jal_fetch",  JL, 1, 0, w_fetch(1, 2'b11));
      cyc("jal_decode", JL, 1, 0, w_decode(2'b11));
      cyc("jal_jal",    JL, 1, 0, ctl(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b11, 0,0));
      cyc("jal_wb",     JL, 1, 0, ctl(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11, 1,0));

      // illegal opcode after a FETCH stall
      cyc("ill_fetch_w", XX, 0, 0, w_fetch(0, 2'b00));
      cyc("ill_fetch",   XX, 1, 0, w_fetch(1, 2'b00));
      cyc("ill_decode",  XX, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 1,1));
      cyc("ill_refetch", XX, 0, 0, w_fetch(0, 2'b00));

      // reset asserted while MEMWRITE is waiting
      cyc("swr_fetch",  SW, 1, 0, w_fetch(1, 2'b01));
      cyc("swr_decode", SW, 1, 0, w_decode(2'b01));
      cyc("swr_memadr", SW, 1, 0, ctl(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
      cyc("swr_wr_w1",  SW, 0, 0, ctl(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_memwrite_mw", {16'd0, MemWrite}, 17'd0);
      chk("rst_memwrite_word", act, ctl(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("post_rst_fetch",  R, 1, 0, w_fetch(1, 2'b00));
      cyc("post_rst_decode", R, 1, 0, w_decode(2'b00));

      repeat (2) @(posedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
